pc_sequencer: RTL

// - Control FSM that sequences the ProgramCounter / PC_Mux datapath of the RAT MCU.
// - Walks the processor through reset, fetch and execute.
// - Drives PC_LD, PC_INC, PC_MUX_SEL and the PC reset.
// - Resolves branch, call and return commands against the Z and C flags.
// - Sits between instruction decode and the PC_Mux -> ProgramCounter pair.

---
 rtl/pc_sequencer_if.sv | 50 +++++
 rtl/pc_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Groups the decode-side commands/flags and the PC datapath strobes of the
// RAT MCU program-counter sequencer.
//   master modport : the sequencer (inputs HALT, BR_CMD, Z, C; drives strobes)
//   slave  modport : decode / PC datapath side (mirror directions)
// Signals:
//   HALT        hold in FETCH
//   BR_CMD[2:0] 0 NONE,1 BRN,2 BREQ,3 BRNE,4 BRCS,5 BRCC,6 CALL,7 RET
//   Z, C        zero / carry flags, consumed in EXEC
//   PC_RST, PC_LD, PC_INC, PC_MUX_SEL[1:0], IR_LD, SP_PUSH, SP_POP
//   STATE[1:0]  debug view of the FSM state
// Build macro PC_SEQ_INTR_EN adds INTR, SEI, CLI (to sequencer) and INT_ACK.
interface pc_sequencer_if;
  logic       HALT;
  logic [2:0] BR_CMD;
  logic       Z;
  logic       C;
  logic       PC_RST;
  logic       PC_LD;
  logic       PC_INC;
  logic [1:0] PC_MUX_SEL;
  logic       IR_LD;
  logic       SP_PUSH;
  logic       SP_POP;
  logic [1:0] STATE;
`ifdef PC_SEQ_INTR_EN
  logic       INTR;
  logic       SEI;
  logic       CLI;
  logic       INT_ACK;

  modport master (
    input  HALT, BR_CMD, Z, C, INTR, SEI, CLI,
    output PC_RST, PC_LD, PC_INC, PC_MUX_SEL, IR_LD, SP_PUSH, SP_POP, STATE, INT_ACK
  );
  modport slave (
    output HALT, BR_CMD, Z, C, INTR, SEI, CLI,
    input  PC_RST, PC_LD, PC_INC, PC_MUX_SEL, IR_LD, SP_PUSH, SP_POP, STATE, INT_ACK
  );
`else
  modport master (
    input  HALT, BR_CMD, Z, C,
    output PC_RST, PC_LD, PC_INC, PC_MUX_SEL, IR_LD, SP_PUSH, SP_POP, STATE
  );
  modport slave (
    output HALT, BR_CMD, Z, C,
    input  PC_RST, PC_LD, PC_INC, PC_MUX_SEL, IR_LD, SP_PUSH, SP_POP, STATE
  );
`endif
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Control FSM sequencing the PC_Mux -> ProgramCounter pair of the RAT MCU:
// INIT (PC held in reset) -> FETCH (latch IR, increment PC) -> EXEC (resolve
// branch / call / return against Z and C) -> FETCH ...
// Ports:
//   CLK    rising-edge clock
//   RST_N  asynchronous active-low reset
//   bus    pc_sequencer_if.master (commands, flags, PC/IR/stack strobes, STATE)
// Parameters:
//   RESET_CYCLES  number of PC_RST cycles after reset release (>=1)
//   INTR_SEL      PC_MUX_SEL code selecting the interrupt vector
// Build macro PC_SEQ_INTR_EN enables the interrupt state, the IE flag and
// the INTR/SEI/CLI/INT_ACK signals; without it INTR is never entered.
module pc_sequencer #(
  parameter int         RESET_CYCLES = 2,
  parameter logic [1:0] INTR_SEL     = 2'b10
) (
  input logic              CLK,
  input logic              RST_N,
  pc_sequencer_if.master   bus
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_INTR  = 2'b11
  } state_e;

  localparam int CNT_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RESET_CYCLES);

  localparam logic [2:0] CMD_BRN  = 3'd1;
  localparam logic [2:0] CMD_BREQ = 3'd2;
  localparam logic [2:0] CMD_BRNE = 3'd3;
  localparam logic [2:0] CMD_BRCS = 3'd4;
  localparam logic [2:0] CMD_BRCC = 3'd5;
  localparam logic [2:0] CMD_CALL = 3'd6;
  localparam logic [2:0] CMD_RET  = 3'd7;

  localparam logic [1:0] SEL_IMMED = 2'b00;
  localparam logic [1:0] SEL_STACK = 2'b01;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mux_sel_q, mux_sel_d;

  logic       pc_rst, pc_ld, pc_inc, ir_ld, sp_push, sp_pop, taken;
  logic [1:0] mux_sel;

`ifdef PC_SEQ_INTR_EN
  logic ie_q, ie_d, int_ack;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_INIT;
      cnt_q     <= CNT_INIT;
      mux_sel_q <= SEL_IMMED;
`ifdef PC_SEQ_INTR_EN
      ie_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mux_sel_q <= mux_sel_d;
`ifdef PC_SEQ_INTR_EN
      ie_q      <= ie_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_rst  = 1'b0;
    pc_ld   = 1'b0;
    pc_inc  = 1'b0;
    ir_ld   = 1'b0;
    sp_push = 1'b0;
    sp_pop  = 1'b0;
    taken   = 1'b0;
    // Select holds its last driven code so the PC_Mux output does not glitch.
    mux_sel = mux_sel_q;
`ifdef PC_SEQ_INTR_EN
    ie_d    = ie_q;
    int_ack = 1'b0;
`endif

    unique case (state_q)
      ST_INIT: begin
        pc_rst = 1'b1;
        cnt_d  = cnt_q - CNT_W'(1);
        // Leave on the edge where the counter hits zero: RESET_CYCLES PC_RST cycles.
        if (cnt_q <= CNT_W'(1)) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        if (!bus.HALT) begin
          ir_ld   = 1'b1;
          pc_inc  = 1'b1;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        unique case (bus.BR_CMD)
          CMD_BRN:  taken = 1'b1;
          CMD_BREQ: taken = bus.Z;
          CMD_BRNE: taken = !bus.Z;
          CMD_BRCS: taken = bus.C;
          CMD_BRCC: taken = !bus.C;
          CMD_CALL: taken = 1'b1;
          default:  taken = 1'b0;
        endcase
        if (bus.BR_CMD == CMD_RET) begin
          pc_ld   = 1'b1;
          sp_pop  = 1'b1;
          mux_sel = SEL_STACK;
        end else if (taken) begin
          pc_ld   = 1'b1;
          mux_sel = SEL_IMMED;
          sp_push = (bus.BR_CMD == CMD_CALL);
        end
        state_d = ST_FETCH;
`ifdef PC_SEQ_INTR_EN
        if (bus.CLI)      ie_d = 1'b0;
        else if (bus.SEI) ie_d = 1'b1;
        // Interrupt acceptance uses IE as it stood entering this EXEC.
        if (bus.INTR && ie_q) state_d = ST_INTR;
`endif
      end

      ST_INTR: begin
`ifdef PC_SEQ_INTR_EN
        pc_ld   = 1'b1;
        sp_push = 1'b1;
        mux_sel = INTR_SEL;
        int_ack = 1'b1;
        ie_d    = 1'b0;
        state_d = ST_FETCH;
`else
        state_d = ST_INIT;
`endif
      end

      default: state_d = ST_INIT;
    endcase

    mux_sel_d = mux_sel;
  end

  assign bus.PC_RST     = pc_rst;
  assign bus.PC_LD      = pc_ld;
  assign bus.PC_INC     = pc_inc;
  assign bus.PC_MUX_SEL = mux_sel;
  assign bus.IR_LD      = ir_ld;
  assign bus.SP_PUSH    = sp_push;
  assign bus.SP_POP     = sp_pop;
  assign bus.STATE      = state_q;
`ifdef PC_SEQ_INTR_EN
  assign bus.INT_ACK    = int_ack;
`endif

endmodule
